// File: rtl/n8_c2_mac_accumulator.sv
// Saturating signed accumulator for 8-bit multiplier products: sums N_TERMS
// products per batch and offers the result on a valid/ready output handshake.
module n8_c2_mac_accumulator #(
   parameter int N_TERMS = 8,
   parameter int ACC_W   = 10
) (
   input  logic             clock,
   input  logic             reset_,
   input  logic [7:0]       p7_p0,
   input  logic             p_valid,
   output logic             p_ready,
   input  logic             clr,
   output logic [ACC_W-1:0] s_out,
   output logic             s_valid,
   input  logic             s_ready,
   output logic             ovf,
   output logic [3:0]       count,
   output logic             state_dbg
);

   // Handshakes: a product moves on a rising edge with p_valid & p_ready; a
   // result moves on a rising edge with s_valid & s_ready. Neither valid waits
   // on its ready, and clr takes priority over both transfers.
   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   localparam logic signed [ACC_W:0] MAX_POS = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_NEG = {2'b11, {(ACC_W-1){1'b0}}};
   localparam logic [3:0]            LAST_CNT = 4'(N_TERMS - 1);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic [3:0]         cnt_q, cnt_d;
   logic signed [ACC_W:0] sum;
   logic               accept;

   assign p_ready = (state_q == ST_ACCUM) && !clr;
   assign accept  = p_valid && p_ready;

   // One guard bit is enough: |acc| <= 2^(ACC_W-1) and |product| <= 128.
   assign sum = $signed({acc_q[ACC_W-1], acc_q})
              + $signed({{(ACC_W-7){p7_p0[7]}}, p7_p0});

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (clr) begin
         state_d = ST_ACCUM;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else if (state_q == ST_DONE) begin
         if (s_ready) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
         end
      end else if (accept) begin
         if (sum > MAX_POS) begin
            acc_d = MAX_POS[ACC_W-1:0];
            ovf_d = 1'b1;
         end else if (sum < MIN_NEG) begin
            acc_d = MIN_NEG[ACC_W-1:0];
            ovf_d = 1'b1;
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
         cnt_d = cnt_q + 4'd1;
         if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s_out     = acc_q;
   assign s_valid   = (state_q == ST_DONE);
   assign ovf       = ovf_q;
   assign count     = cnt_q;
   assign state_dbg = state_q;

endmodule

// File: doc/n8_c2_mac_accumulator.md
# n8_c2_mac_accumulator

Sequential signed accumulator placed directly downstream of the 4×4 two's-complement integer multiplier. It consumes the 8-bit two's-complement products one per handshake and sums a batch of N_TERMS of them into a saturating ACC_W-bit two's-complement result. It presents the result on an output handshake, which gives the datapath a dot-product / multiply-accumulate stage.

## Interface
- N_TERMS, default 8: products per batch; legal range 1..15.
- ACC_W, default 10: accumulator and result width, two's complement; legal range 9..16.
- clock  in  1  system clock; all state changes on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- p7_p0  in  8  two's-complement product, as produced by the multiplier.
- p_valid  in  1  p7_p0 is valid this cycle.
- p_ready  out  1  block accepts a product this cycle. A product transfers on a rising edge with p_valid & p_ready.
- clr  in  1  synchronous batch abort.
- s_out  out  ACC_W  accumulated result; also shows the running sum while accumulating.
- s_valid  out  1  s_out holds a completed batch.
- s_ready  in  1  consumer takes the result. Transfer happens on s_valid & s_ready.
- ovf  out  1  sticky flag: saturation occurred in the current batch.
- count  out  4  products accepted in the current batch.

## Operation
- Two states:
  - ACCUM: collecting products.
  - DONE: holding the result.
- Reset (reset_ low, immediate, asynchronous) forces:
  - state = ACCUM
  - accumulator = 0, so s_out = 0
  - count = 0, ovf = 0, s_valid = 0
- p_ready = (state == ACCUM) & ~clr. It is combinational from state and clr.
- s_valid = (state == DONE). It is registered via state.
- Accept in ACCUM:
  - Sign-extend p7_p0 to ACC_W+1 bits and add it to the sign-extended accumulator.
  - If the sum > 2^(ACC_W-1)-1, load the maximum positive value and set ovf.
  - If the sum < -2^(ACC_W-1), load the minimum negative value and set ovf.
  - Otherwise load the sum.
  - count increments.
- Saturation does not stop the batch. Later products add to the saturated value, and ovf stays 1 until the batch ends.
- ACCUM → DONE on the edge that accepts product number N_TERMS. That edge loads the final value, and count shows N_TERMS.
- DONE:
  - s_out, ovf and count are frozen.
  - p_valid is ignored.
- DONE → ACCUM on the edge with s_ready high. The same edge clears the accumulator, count and ovf.
- clr high at an edge, in either state:
  - accumulator, count and ovf are cleared and state = ACCUM.
  - Any product offered that cycle is not accepted (p_ready is low), so it is dropped.
  - In DONE, the result is discarded without being transferred.
- Gaps in p_valid are allowed. With p_valid low, state is held.

## Timing
- Accumulator latency: a product accepted at edge k is reflected in s_out from just after edge k.
- s_valid rises just after the edge that accepts the last product, so the result is available 0 cycles after the final accept.
- Minimum batch period is N_TERMS+1 cycles: N_TERMS accept cycles plus at least one DONE cycle.
- With s_ready tied high, DONE lasts exactly one cycle and p_ready returns in the following cycle.
- Backpressure: while s_ready is low in DONE, s_out, ovf and count hold indefinitely and p_ready stays 0.
- Precedence: reset_ > clr > s_ready handshake > product accept.
- Defaults: 8 multiplier products (range -56..64) span -448..512. Only 8×64 overflows, by exactly 1.

## Test plan
- Reset: drive reset_ low mid-batch after 3 accepts → s_out=0, count=0, ovf=0, s_valid=0 asynchronously; p_ready=1 once reset_ is released.
- Basic batch: products 1..8 with a p_valid gap after the 4th, s_ready=1 → s_valid for 1 cycle with s_out=36, ovf=0, count=8; next cycle count=0 and p_ready=1.
- Positive saturation: 8×0x40 → after 7 accepts s_out=448; 8th → s_out=511 (0x1FF), ovf=1.
- Negative saturation: 8×0x80 → 5th accept saturates to -512 (0x200), ovf=1; after 8 accepts s_out=0x200, ovf=1.
- Backpressure: complete a batch with s_ready=0 for 3 cycles and p_valid=1 throughout → s_out and count stable, p_ready=0, no product accepted; s_ready=1 → clear, return to ACCUM.
- Abort: 3 products (5, -3, 7 → s_out=9), then clr=1 with p_valid=1 and p7_p0=20 → p_ready=0, next cycle s_out=0, count=0; next batch unaffected by 20.
